// File: rtl/kahan_finish.sv
// kahan_finish: folds per-beat Kahan partial pairs into one compensated minifloat result
module kahan_step #(
  parameter int EXP_WIDTH_I = 5,
  parameter int MANT_WIDTH_I = 2,
  parameter int STEP_LAT = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [EXP_WIDTH_I+MANT_WIDTH_I:0]  elem_i,
  input  logic [EXP_WIDTH_I+MANT_WIDTH_I:0]  sum_i,
  input  logic [EXP_WIDTH_I+MANT_WIDTH_I:0]  c_i,
  output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]  sum_o,
  output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]  c_o
);
  localparam int E = EXP_WIDTH_I;
  localparam int M = MANT_WIDTH_I;
  localparam int W = 1 + E + M;
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam int FW = 2 * BIAS + M;
  localparam logic [W-1:0] SIGN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] NAN = {1'b0, {(W-1){1'b1}}};
  localparam logic [E+M-1:0] INF = {{E{1'b1}}, {M{1'b0}}};
  // Every finite operand is an exact multiple of the smallest subnormal, so
  // adding in fixed point and rounding once gives a correctly rounded sum.
  function automatic logic signed [FW+1:0] to_fix(input logic [W-1:0] x);
    logic [FW+1:0] mag;
    mag = (x[W-2:M] == '0) ? {{(FW+2-M){1'b0}}, x[M-1:0]}
                           : {{(FW+1-M){1'b0}}, 1'b1, x[M-1:0]} << (x[W-2:M] - 1'b1);
    return x[W-1] ? -$signed(mag) : $signed(mag);
  endfunction
  function automatic logic [W-1:0] from_fix(input logic signed [FW+1:0] v);
    logic [FW:0] mag, sh;
    logic [E+M-1:0] em;
    int p;
    mag = (FW+1)'(v[FW+1] ? -v : v);
    p = 0;
    for (int i = 0; i <= FW; i++) if (mag[i]) p = i;
    sh = mag << (FW - p);
    em = {E'(p - M + 1), sh[FW-1 -: M]}
       + {{(E+M-1){1'b0}}, sh[FW-M-1] & (sh[FW-M] | (|sh[FW-M-2:0]))};
    if (mag < (FW+1)'(1 << M)) em = mag[E+M-1:0];
    else if (p - M + 1 >= (1 << E) - 1) em = INF;
    return (mag == '0) ? '0 : {v[FW+1], em};
  endfunction
  function automatic logic [W-1:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b);
    return (&a[W-2:M] | &b[W-2:M]) ? NAN : from_fix(to_fix(a) + to_fix(b));
  endfunction
  logic [W-1:0] y, t, cn;
  assign y = fadd(elem_i, c_i ^ SIGN);
  assign t = fadd(sum_i, y);
  assign cn = fadd(fadd(t, sum_i ^ SIGN), y ^ SIGN);
  // The consumer registers the result on the STEP_LAT-th edge, so only STEP_LAT-1 stages live here.
  if (STEP_LAT == 1) begin : g_comb
    assign sum_o = t;
    assign c_o = cn;
  end else begin : g_pipe
    logic [STEP_LAT-2:0][2*W-1:0] pipe;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) pipe <= '0;
      else begin
        pipe[0] <= {t, cn};
        for (int i = 1; i < STEP_LAT - 1; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign {sum_o, c_o} = pipe[STEP_LAT-2];
  end
endmodule

module kahan_finish #(
  parameter int EXP_WIDTH_I = 5,
  parameter int MANT_WIDTH_I = 2,
  parameter int STEP_LAT = 2,
  parameter int NUM_BEATS = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [EXP_WIDTH_I+MANT_WIDTH_I:0]  sum_a_i,
  input  logic [EXP_WIDTH_I+MANT_WIDTH_I:0]  c_a_i,
  input  logic [EXP_WIDTH_I+MANT_WIDTH_I:0]  sum_b_i,
  input  logic [EXP_WIDTH_I+MANT_WIDTH_I:0]  c_b_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]  sum_o,
  output logic [EXP_WIDTH_I+MANT_WIDTH_I:0]  c_o
);
  localparam int W = 1 + EXP_WIDTH_I + MANT_WIDTH_I;
  localparam int CW = STEP_LAT > 1 ? $clog2(STEP_LAT) : 1;
  localparam int BW = NUM_BEATS > 1 ? $clog2(NUM_BEATS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_LAT > 1 ? STEP_LAT - 2 : 0);
  localparam logic [BW-1:0] BEAT_LAST = BW'(NUM_BEATS - 1);
  localparam logic [W-1:0] SIGN = {1'b1, {(W-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;
  state_t state, n_state;
  logic [3:0][W-1:0] ops, n_ops;
  logic [1:0] op, n_op;
  logic [CW-1:0] cnt, n_cnt;
  logic [BW-1:0] beat, n_beat;
  logic [W-1:0] s, n_s, c, n_c, step_sum, step_c;
  logic cap;
  kahan_step #(.EXP_WIDTH_I(EXP_WIDTH_I), .MANT_WIDTH_I(MANT_WIDTH_I), .STEP_LAT(STEP_LAT)) u_step (
    .clk_i(clk_i), .rst_ni(~rst_i), .elem_i(ops[op]), .sum_i(s), .c_i(c),
    .sum_o(step_sum), .c_o(step_c)
  );
  assign cap = (state == ISSUE && STEP_LAT == 1) || (state == WAIT && cnt == CNT_LAST);
  always_comb begin
    n_state = state;
    n_ops = ops;
    n_op = op;
    n_cnt = cnt;
    n_beat = beat;
    n_s = s;
    n_c = c;
    case (state)
      IDLE: if (in_valid_i) begin
        n_ops = {c_b_i ^ SIGN, sum_b_i, c_a_i ^ SIGN, sum_a_i};
        n_op = 2'd0;
        n_state = (beat == '0) ? LOAD : ISSUE;
      end
      LOAD: begin
        n_s = ops[0];
        n_c = '0;
        n_op = 2'd1;
        n_state = ISSUE;
      end
      ISSUE, WAIT: if (cap) begin
        n_s = step_sum;
        n_c = step_c;
        n_op = op + 2'd1;
        n_cnt = '0;
        n_state = (op != 2'd3) ? ISSUE : (beat != BEAT_LAST) ? IDLE : DONE;
        n_beat = (op == 2'd3 && beat != BEAT_LAST) ? beat + 1'b1 : beat;
      end else begin
        n_state = WAIT;
        n_cnt = (state == ISSUE) ? '0 : cnt + 1'b1;
      end
      DONE: if (out_ready_i) begin
        n_state = IDLE;
        n_s = '0;
        n_c = '0;
        n_beat = '0;
      end
      default: n_state = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      ops <= '0;
      op <= '0;
      cnt <= '0;
      beat <= '0;
      s <= '0;
      c <= '0;
    end else begin
      state <= n_state;
      ops <= n_ops;
      op <= n_op;
      cnt <= n_cnt;
      beat <= n_beat;
      s <= n_s;
      c <= n_c;
    end
  end
  assign in_ready_o = state == IDLE;
  assign out_valid_o = state == DONE;
  assign sum_o = s;
  assign c_o = c;
endmodule
